// File: rtl/dbg_cmd_pkg.sv
// Shared widths, op/state enums, the queued-request struct and the command-word encoder
// for the debug-governor command transmitter.
package dbg_cmd_pkg;

  localparam int CMD_DATA_W = 16;
  localparam int CMD_OP_W   = 10;
  localparam int CMD_W      = 27;
  localparam int OP_IDX_W   = 4;

  typedef enum logic [OP_IDX_W-1:0] {
    OP_PAUSE_ON   = 4'd0,
    OP_PAUSE_OFF  = 4'd1,
    OP_DROP_ON    = 4'd2,
    OP_DROP_OFF   = 4'd3,
    OP_INJECT_ON  = 4'd4,
    OP_INJECT_OFF = 4'd5,
    OP_LOG_ON     = 4'd6,
    OP_LOG_OFF    = 4'd7,
    OP_LOG_CLR    = 4'd8,
    OP_LOG_RD     = 4'd9
  } dbg_op_e;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    SEND      = 2'd1,
    WAIT_DONE = 2'd2
  } tx_state_e;

  // One queued request: 4 + 16 + 1 = 21 bits.
  typedef struct packed {
    logic [OP_IDX_W-1:0]   op;
    logic [CMD_DATA_W-1:0] data;
    logic                  cont;
  } req_t;

  function automatic logic [CMD_W-1:0] encode_cmd(
    input logic [OP_IDX_W-1:0]   op,
    input logic [CMD_DATA_W-1:0] data,
    input logic                  cont
  );
    logic [CMD_OP_W-1:0] onehot;
    onehot = CMD_OP_W'(1) << op;
    return {data, onehot, cont};
  endfunction

endpackage

// File: rtl/dbg_cmd_fifo.sv
// Generic synchronous FIFO with push/pop, full/empty and occupancy count.
// Latency: pushed entry visible at pop_dat the cycle after the push edge.
// Backpressure: push ignored while full, pop ignored while empty; push+pop on one edge keeps count.
module dbg_cmd_fifo #(
  parameter int WIDTH  = 21,
  parameter int DEPTH  = 4,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_dat,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_dat,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             push_ok;
  logic             pop_ok;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign pop_dat = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset; occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= push_dat;
  end

endmodule

// File: rtl/dbg_cmd_tx.sv
// Debug-governor command transmitter: queues host requests and sends encoded 27-bit words.
// Latency: request at edge N -> cmd_out_TVALID after edge N+2; >=1 IDLE cycle between commands.
// Backpressure: req_ready = !full; with DBG_CMD_TX_WAIT_DONE_EN each command also waits for done_in or timeout.
module dbg_cmd_tx
  import dbg_cmd_pkg::*;
#(
  parameter int FIFO_DEPTH     = 4,
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int TO_W           = 11,
  localparam int CNT_W         = $clog2(FIFO_DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [3:0]       req_op,
  input  logic [15:0]      req_data,
  input  logic             req_cont,
  output logic [26:0]      cmd_out_TDATA,
  output logic             cmd_out_TVALID,
  input  logic             cmd_out_TREADY,
  input  logic [9:0]       done_in,
  output logic             busy,
  output logic [CNT_W-1:0] pending,
  output logic             cmd_done,
  output logic             cmd_timeout,
  output logic             err_badop
);

  tx_state_e  state;
  tx_state_e  state_nxt;
  req_t       push_dat;
  req_t       head_dat;
  logic       fifo_full;
  logic       fifo_empty;
  logic       fifo_pop;
  logic       req_acc;
  logic       bad_op;
  logic       head_vld_q;
  logic       done_set;
  logic [CMD_W-1:0] cmd_word;

  assign push_dat = '{op: req_op, data: req_data, cont: req_cont};
  assign req_acc  = req_valid && req_ready;
  assign bad_op   = (req_op > OP_LOG_RD);

  dbg_cmd_fifo #(
    .WIDTH ($bits(req_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (req_acc && !bad_op),
    .push_dat (push_dat),
    .pop      (fifo_pop),
    .pop_dat  (head_dat),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .count    (pending)
  );

  assign req_ready      = !fifo_full;
  assign cmd_out_TVALID = (state == SEND);
  assign cmd_out_TDATA  = cmd_word;
  assign busy           = (state != IDLE) || !fifo_empty;

`ifdef DBG_CMD_TX_WAIT_DONE_EN
  logic [OP_IDX_W-1:0] op_q;
  logic [TO_W-1:0]     to_cnt;
  logic                op_done;
  logic                to_expired;
  logic                to_clr;
  logic                to_set;

  assign op_done    = done_in[op_q];
  assign to_expired = (to_cnt == TO_W'(TIMEOUT_CYCLES - 1));
`else
  logic unused_done;
  localparam int unused_to_cfg = TIMEOUT_CYCLES + TO_W;
  assign unused_done = ^done_in;
  assign cmd_timeout = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    fifo_pop  = 1'b0;
    done_set  = 1'b0;
`ifdef DBG_CMD_TX_WAIT_DONE_EN
    to_clr    = 1'b0;
    to_set    = 1'b0;
`endif
    case (state)
      IDLE: begin
        // head_vld_q lags the FIFO by a cycle, staging the head before launch.
        if (head_vld_q && !fifo_empty) begin
          fifo_pop  = 1'b1;
          state_nxt = SEND;
        end
      end
      SEND: begin
        if (cmd_out_TREADY) begin
`ifdef DBG_CMD_TX_WAIT_DONE_EN
          if (op_done) begin
            done_set  = 1'b1;
            state_nxt = IDLE;
          end else begin
            to_clr    = 1'b1;
            state_nxt = WAIT_DONE;
          end
`else
          done_set  = 1'b1;
          state_nxt = IDLE;
`endif
        end
      end
`ifdef DBG_CMD_TX_WAIT_DONE_EN
      WAIT_DONE: begin
        if (op_done) begin
          done_set  = 1'b1;
          state_nxt = IDLE;
        end else if (to_expired) begin
          to_set    = 1'b1;
          state_nxt = IDLE;
        end
      end
`endif
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cmd_word   <= '0;
      head_vld_q <= 1'b0;
      cmd_done   <= 1'b0;
      err_badop  <= 1'b0;
    end else begin
      state      <= state_nxt;
      head_vld_q <= !fifo_empty;
      cmd_done   <= done_set;
      err_badop  <= req_acc && bad_op;
      if (fifo_pop) cmd_word <= encode_cmd(head_dat.op, head_dat.data, head_dat.cont);
    end
  end

`ifdef DBG_CMD_TX_WAIT_DONE_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      op_q        <= '0;
      to_cnt      <= '0;
      cmd_timeout <= 1'b0;
    end else begin
      cmd_timeout <= to_set;
      if (fifo_pop) op_q <= head_dat.op;
      if (to_clr) begin
        to_cnt <= '0;
      end else if (state == WAIT_DONE) begin
        to_cnt <= to_cnt + 1'b1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_dbg_cmd_tx.sv
// Directed self-checking bench for dbg_cmd_tx; expectations adapt to DBG_CMD_TX_WAIT_DONE_EN.
module tb_dbg_cmd_tx;

  logic        CLOCK_50;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [3:0]  req_op;
  logic [15:0] req_data;
  logic        req_cont;
  logic [26:0] cmd_out_TDATA;
  logic        cmd_out_TVALID;
  logic        cmd_out_TREADY;
  logic [9:0]  done_in;
  logic        busy;
  logic [2:0]  pending;
  logic        cmd_done;
  logic        cmd_timeout;
  logic        err_badop;

  int tests_run    = 0;
  int tests_failed = 0;

  dbg_cmd_tx dut (
    .clk            (CLOCK_50),
    .rst            (rst),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_op         (req_op),
    .req_data       (req_data),
    .req_cont       (req_cont),
    .cmd_out_TDATA  (cmd_out_TDATA),
    .cmd_out_TVALID (cmd_out_TVALID),
    .cmd_out_TREADY (cmd_out_TREADY),
    .done_in        (done_in),
    .busy           (busy),
    .pending        (pending),
    .cmd_done       (cmd_done),
    .cmd_timeout    (cmd_timeout),
    .err_badop      (err_badop)
  );

  initial CLOCK_50 = 1'b0;
  always #5 CLOCK_50 = ~CLOCK_50;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick;
    @(posedge CLOCK_50);
    #1;
  endtask

  task automatic send_req(input logic [3:0] op, input logic [15:0] d, input logic c);
    req_valid = 1'b1;
    req_op    = op;
    req_data  = d;
    req_cont  = c;
    tick;
    req_valid = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    tick;
    tick;
    rst = 1'b0;
    tests_run++; if (req_ready !== 1'b1) begin tests_failed++; $display("FAIL reset_req_ready: got %b want 1", req_ready); end
    tests_run++; if (cmd_out_TVALID !== 1'b0) begin tests_failed++; $display("FAIL reset_tvalid: got %b want 0", cmd_out_TVALID); end
    tests_run++; if (cmd_out_TDATA !== 27'h0) begin tests_failed++; $display("FAIL reset_tdata: got %h want 0", cmd_out_TDATA); end
    tests_run++; if ({busy, pending, cmd_done, cmd_timeout, err_badop} !== 7'b0) begin
      tests_failed++; $display("FAIL reset_status: got busy=%b pending=%0d done=%b to=%b bad=%b want all 0",
                               busy, pending, cmd_done, cmd_timeout, err_badop);
    end
  endtask

  task automatic test_basic;
    send_req(4'd2, 16'h0000, 1'b0);
    tests_run++; if (cmd_out_TVALID !== 1'b0) begin tests_failed++; $display("FAIL basic_tvalid_n0: got %b want 0", cmd_out_TVALID); end
    tick;
    tests_run++; if (cmd_out_TVALID !== 1'b0) begin tests_failed++; $display("FAIL basic_tvalid_n1: got %b want 0", cmd_out_TVALID); end
    tick;
    tests_run++; if (cmd_out_TVALID !== 1'b1) begin tests_failed++; $display("FAIL basic_tvalid_n2: got %b want 1", cmd_out_TVALID); end
    tests_run++; if (cmd_out_TDATA !== 27'h0000008) begin tests_failed++; $display("FAIL basic_tdata: got %h want 0000008", cmd_out_TDATA); end
    cmd_out_TREADY = 1'b1;
    tick;
    cmd_out_TREADY = 1'b0;
    tests_run++; if (cmd_out_TVALID !== 1'b0) begin tests_failed++; $display("FAIL basic_tvalid_after_hs: got %b want 0", cmd_out_TVALID); end
`ifdef DBG_CMD_TX_WAIT_DONE_EN
    // A done pulse for another op (3) must be ignored.
    for (int i = 0; i < 4; i++) begin
      done_in = (i == 1) ? 10'h008 : 10'h000;
      tick;
      tests_run++; if (cmd_done !== 1'b0 || busy !== 1'b1) begin
        tests_failed++; $display("FAIL basic_wait_%0d: got done=%b busy=%b want done=0 busy=1", i, cmd_done, busy);
      end
    end
    done_in = 10'h004;
    tick;
    done_in = 10'h000;
`endif
    tests_run++; if (cmd_done !== 1'b1) begin tests_failed++; $display("FAIL basic_cmd_done: got %b want 1", cmd_done); end
    tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL basic_busy_fall: got %b want 0", busy); end
    tick;
    tests_run++; if (cmd_done !== 1'b0) begin tests_failed++; $display("FAIL basic_done_pulse: got %b want 0", cmd_done); end
  endtask

  task automatic test_stall;
    send_req(4'd4, 16'h5555, 1'b0);
    tick;
    tick;
    for (int i = 0; i < 3; i++) begin
      tests_run++; if (cmd_out_TVALID !== 1'b1 || cmd_out_TDATA !== 27'h2AAA820) begin
        tests_failed++; $display("FAIL stall_hold_%0d: got valid=%b data=%h want valid=1 data=2aaa820", i, cmd_out_TVALID, cmd_out_TDATA);
      end
      tick;
    end
    // done_in for this op coincides with the handshake: completes immediately in either build.
    cmd_out_TREADY = 1'b1;
    done_in        = 10'h010;
    tick;
    cmd_out_TREADY = 1'b0;
    done_in        = 10'h000;
    tests_run++; if (cmd_out_TVALID !== 1'b0 || cmd_done !== 1'b1 || busy !== 1'b0) begin
      tests_failed++; $display("FAIL stall_complete: got valid=%b done=%b busy=%b want 0 1 0", cmd_out_TVALID, cmd_done, busy);
    end
    tick;
  endtask

  task automatic test_back_to_back;
    logic [3:0]  ops   [5] = '{4'd0, 4'd1, 4'd3, 4'd5, 4'd7};
    logic [26:0] exp_w [5] = '{27'h0000802, 27'h0001005, 27'h0001810, 27'h0002041, 27'h0002900};
    int accepted = 0;
    int n;
    cmd_out_TREADY = 1'b0;
    for (int i = 0; i < 5; i++) begin
      req_valid = 1'b1;
      req_op    = ops[i];
      req_data  = 16'(i + 1);
      req_cont  = i[0];
      if (req_ready === 1'b1) accepted++;
      tick;
    end
    tests_run++; if (accepted !== 5) begin tests_failed++; $display("FAIL b2b_accepted: got %0d want 5", accepted); end
    tests_run++; if (pending !== 3'd4 || req_ready !== 1'b0) begin
      tests_failed++; $display("FAIL b2b_full: got pending=%0d ready=%b want 4 0", pending, req_ready);
    end
    req_op = 4'd8;
    tick;
    req_valid = 1'b0;
    tests_run++; if (pending !== 3'd4) begin tests_failed++; $display("FAIL b2b_reject_when_full: got pending=%0d want 4", pending); end
    for (int k = 0; k < 5; k++) begin
      n = 0;
      while (cmd_out_TVALID !== 1'b1 && n < 20) begin tick; n++; end
      tests_run++; if (cmd_out_TVALID !== 1'b1 || cmd_out_TDATA !== exp_w[k]) begin
        tests_failed++; $display("FAIL b2b_word_%0d: got valid=%b data=%h want valid=1 data=%h", k, cmd_out_TVALID, cmd_out_TDATA, exp_w[k]);
      end
      cmd_out_TREADY = 1'b1;
      done_in        = 10'(1) << ops[k];
      tick;
      cmd_out_TREADY = 1'b0;
      done_in        = 10'h000;
    end
    n = 0;
    for (int i = 0; i < 10; i++) begin
      if (cmd_out_TVALID === 1'b1) n++;
      tick;
    end
    tests_run++; if (n !== 0 || pending !== 3'd0) begin
      tests_failed++; $display("FAIL b2b_drained: got extra_valid=%0d pending=%0d want 0 0", n, pending);
    end
  endtask

  task automatic test_timeout;
    int n;
    send_req(4'd6, 16'h0000, 1'b1);
    send_req(4'd9, 16'hABCD, 1'b0);
    n = 0;
    while (cmd_out_TVALID !== 1'b1 && n < 10) begin tick; n++; end
    tests_run++; if (cmd_out_TVALID !== 1'b1 || cmd_out_TDATA !== 27'h0000081) begin
      tests_failed++; $display("FAIL to_first_word: got valid=%b data=%h want valid=1 data=0000081", cmd_out_TVALID, cmd_out_TDATA);
    end
    cmd_out_TREADY = 1'b1;
    tick;
    cmd_out_TREADY = 1'b0;
`ifdef DBG_CMD_TX_WAIT_DONE_EN
    n = 0;
    while (cmd_timeout !== 1'b1 && n < 1100) begin
      tick;
      n++;
    end
    tests_run++; if (n !== 1024) begin tests_failed++; $display("FAIL to_cycles: got %0d want 1024", n); end
    tests_run++; if (cmd_done !== 1'b0) begin tests_failed++; $display("FAIL to_no_done: got %b want 0", cmd_done); end
`else
    tests_run++; if (cmd_done !== 1'b1) begin tests_failed++; $display("FAIL to_done_at_hs: got %b want 1", cmd_done); end
`endif
    n = 0;
    while (cmd_out_TVALID !== 1'b1 && n < 10) begin
      if (cmd_timeout === 1'b1 && n > 0) n = 100;
      tick;
      n++;
    end
    tests_run++; if (cmd_out_TVALID !== 1'b1 || cmd_out_TDATA !== 27'h55E6C00) begin
      tests_failed++; $display("FAIL to_next_word: got valid=%b data=%h want valid=1 data=55e6c00", cmd_out_TVALID, cmd_out_TDATA);
    end
    cmd_out_TREADY = 1'b1;
    done_in        = 10'h200;
    tick;
    cmd_out_TREADY = 1'b0;
    done_in        = 10'h000;
    tests_run++; if (cmd_done !== 1'b1 || cmd_timeout !== 1'b0) begin
      tests_failed++; $display("FAIL to_next_done: got done=%b timeout=%b want 1 0", cmd_done, cmd_timeout);
    end
    tick;
  endtask

  task automatic test_badop;
    int n = 0;
    send_req(4'd12, 16'h1234, 1'b0);
    tests_run++; if (err_badop !== 1'b1) begin tests_failed++; $display("FAIL badop_pulse: got %b want 1", err_badop); end
    tests_run++; if (pending !== 3'd0) begin tests_failed++; $display("FAIL badop_pending: got %0d want 0", pending); end
    tick;
    tests_run++; if (err_badop !== 1'b0) begin tests_failed++; $display("FAIL badop_one_cycle: got %b want 0", err_badop); end
    for (int i = 0; i < 5; i++) begin
      if (cmd_out_TVALID === 1'b1) n++;
      tick;
    end
    tests_run++; if (n !== 0) begin tests_failed++; $display("FAIL badop_no_tvalid: got %0d valid cycles want 0", n); end
  endtask

  task automatic test_reset_mid;
    int n = 0;
    cmd_out_TREADY = 1'b0;
    send_req(4'd1, 16'h0011, 1'b0);
    send_req(4'd2, 16'h0022, 1'b0);
    send_req(4'd3, 16'h0033, 1'b1);
    tests_run++; if (cmd_out_TVALID !== 1'b1 || pending !== 3'd2) begin
      tests_failed++; $display("FAIL rstmid_setup: got valid=%b pending=%0d want 1 2", cmd_out_TVALID, pending);
    end
    rst = 1'b1;
    tick;
    rst = 1'b0;
    tests_run++; if (cmd_out_TVALID !== 1'b0 || pending !== 3'd0 || busy !== 1'b0 || req_ready !== 1'b1) begin
      tests_failed++; $display("FAIL rstmid_cleared: got valid=%b pending=%0d busy=%b ready=%b want 0 0 0 1",
                               cmd_out_TVALID, pending, busy, req_ready);
    end
    cmd_out_TREADY = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if (cmd_out_TVALID === 1'b1) n++;
      tick;
    end
    cmd_out_TREADY = 1'b0;
    tests_run++; if (n !== 0 || cmd_done !== 1'b0) begin
      tests_failed++; $display("FAIL rstmid_residual: got valid_cycles=%0d done=%b want 0 0", n, cmd_done);
    end
  endtask

  initial begin
    rst            = 1'b1;
    req_valid      = 1'b0;
    req_op         = 4'd0;
    req_data       = 16'h0000;
    req_cont       = 1'b0;
    cmd_out_TREADY = 1'b0;
    done_in        = 10'h000;
    test_reset;
    test_basic;
    test_stall;
    test_back_to_back;
    test_timeout;
    test_badop;
    test_reset_mid;
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
